// File: rtl/evt_pkt_extractor_if.sv
// Datapath bundle for evt_pkt_extractor: upstream input, downstream output and event sink.
// A word moves upstream on in_wr & in_rdy; out_wr is only raised while out_rdy=1 and evt_wr only while evt_full=0, so every strobe is a completed transfer.
interface evt_pkt_extractor_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic [CTRL_WIDTH-1:0] in_ctrl;
  logic                  in_wr;
  logic                  in_rdy;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CTRL_WIDTH-1:0] out_ctrl;
  logic                  out_wr;
  logic                  out_rdy;
  logic [DATA_WIDTH-1:0] evt_word;
  logic                  evt_wr;
  logic                  evt_full;
  logic                  evt_pkt_done;
  logic [31:0]           evt_pkt_count;
  logic [15:0]           evt_err_count;

  modport master (
    input  in_data, in_ctrl, in_wr, out_rdy, evt_full,
    output in_rdy, out_data, out_ctrl, out_wr, evt_word, evt_wr, evt_pkt_done,
           evt_pkt_count, evt_err_count
  );

  modport slave (
    output in_data, in_ctrl, in_wr, out_rdy, evt_full,
    input  in_rdy, out_data, out_ctrl, out_wr, evt_word, evt_wr, evt_pkt_done,
           evt_pkt_count, evt_err_count
  );
endinterface

// File: rtl/evt_pkt_extractor.sv
// Event packet extractor: forwards normal packets, pulls payload words out of event packets.
// Define EVT_EXTRACT_FWD_EN to also forward event packets unchanged on the output datapath.
module evt_pkt_extractor #(
  parameter int          DATA_WIDTH        = 64,
  parameter int          CTRL_WIDTH        = 8,
  parameter int          NUM_WORDS_IN_HDR  = 7,
  parameter int          NUM_WORDS_PAYLOAD = 8,
  parameter logic [15:0] EVT_ETHERTYPE     = 16'h88B5
) (
  input  logic                 clk,
  input  logic                 reset,
  evt_pkt_extractor_if.master  bus,
  output logic [2:0]           dbg_state
);
  localparam int FW = DATA_WIDTH + CTRL_WIDTH;
`ifdef EVT_EXTRACT_FWD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, HOLD1, HOLD2, FLUSH, PASS, EVT_HDR, EVT_PLD, DROP} state_t;

  logic [FW-1:0]         mem [8];
  logic [2:0]            wr_ptr, rd_ptr;
  logic [3:0]            fcount;
  logic                  empty, full, wr_en, pop;
  logic [DATA_WIDTH-1:0] head_data;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic                  head_eop;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] h0_data, h1_data, out_data_c;
  logic [CTRL_WIDTH-1:0] h0_ctrl, h1_ctrl, out_ctrl_c;
  logic                  flush_sel, flush_end, flush_evt;
  logic [7:0]            cnt, cnt_ld_val;
  logic [31:0]           pkt_cnt;
  logic [15:0]           err_cnt;
  logic out_wr_c, evt_wr_c, done_c, ld_h0, ld_h1, flush_go, flush_end_n, flush_evt_n;
  logic cnt_ld, cnt_inc, inc_good, inc_err, fwd_ok;

  assign empty     = (fcount == 4'd0);
  assign full      = (fcount == 4'd8);
  assign wr_en     = bus.in_wr & ~full;
  assign head_data = mem[rd_ptr][DATA_WIDTH-1:0];
  assign head_ctrl = mem[rd_ptr][FW-1:DATA_WIDTH];
  assign head_eop  = (head_ctrl != '0);

  always_comb begin
    state_n     = state;
    pop         = 1'b0;
    out_wr_c    = 1'b0;
    out_data_c  = head_data;
    out_ctrl_c  = head_ctrl;
    evt_wr_c    = 1'b0;
    done_c      = 1'b0;
    ld_h0       = 1'b0;
    ld_h1       = 1'b0;
    flush_go    = 1'b0;
    flush_end_n = 1'b0;
    flush_evt_n = 1'b0;
    cnt_ld      = 1'b0;
    cnt_ld_val  = 8'd0;
    cnt_inc     = 1'b0;
    inc_good    = 1'b0;
    inc_err     = 1'b0;
    fwd_ok      = ~FWD | bus.out_rdy;
    case (state)
      IDLE: if (!empty) begin
        if (head_eop) begin
          ld_h0   = 1'b1;
          pop     = 1'b1;
          state_n = HOLD1;
        end else begin
          state_n = PASS;
        end
      end
      HOLD1: if (!empty) begin
        ld_h1 = 1'b1;
        pop   = 1'b1;
        if (head_eop) begin
          flush_go    = 1'b1;
          flush_end_n = 1'b1;
          state_n     = FLUSH;
        end else begin
          state_n = HOLD2;
        end
      end
      HOLD2: if (!empty) begin
        // Word 2 carries the ethertype; a framing word can never start an event.
        if (!head_eop && head_data[31:16] == EVT_ETHERTYPE) begin
          cnt_ld     = 1'b1;
          cnt_ld_val = FWD ? 8'd2 : 8'd3;
          if (FWD) begin
            flush_go    = 1'b1;
            flush_evt_n = 1'b1;
            state_n     = FLUSH;
          end else begin
            pop     = 1'b1;
            state_n = EVT_HDR;
          end
        end else begin
          flush_go = 1'b1;
          state_n  = FLUSH;
        end
      end
      FLUSH: begin
        out_data_c = flush_sel ? h1_data : h0_data;
        out_ctrl_c = flush_sel ? h1_ctrl : h0_ctrl;
        out_wr_c   = bus.out_rdy;
        if (bus.out_rdy && flush_sel)
          state_n = flush_end ? IDLE : (flush_evt ? EVT_HDR : PASS);
      end
      PASS: if (!empty && bus.out_rdy) begin
        out_wr_c = 1'b1;
        pop      = 1'b1;
        if (head_eop) state_n = IDLE;
      end
      EVT_HDR: if (!empty && fwd_ok) begin
        pop      = 1'b1;
        out_wr_c = FWD;
        if (head_eop) begin
          inc_err = 1'b1;
          state_n = IDLE;
        end else if (cnt == 8'(NUM_WORDS_IN_HDR - 1)) begin
          cnt_ld  = 1'b1;
          state_n = EVT_PLD;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      EVT_PLD: if (!empty && fwd_ok && !bus.evt_full) begin
        pop      = 1'b1;
        out_wr_c = FWD;
        // Violating words are consumed but never written to the event sink.
        if (cnt == 8'(NUM_WORDS_PAYLOAD - 1)) begin
          if (head_eop) begin
            evt_wr_c = 1'b1;
            done_c   = 1'b1;
            inc_good = 1'b1;
            state_n  = IDLE;
          end else begin
            inc_err = 1'b1;
            state_n = DROP;
          end
        end else if (head_eop) begin
          inc_err = 1'b1;
          state_n = IDLE;
        end else begin
          evt_wr_c = 1'b1;
          cnt_inc  = 1'b1;
        end
      end
      DROP: if (!empty && fwd_ok) begin
        pop      = 1'b1;
        out_wr_c = FWD;
        if (head_eop) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (reset) begin
      pop      = 1'b0;
      out_wr_c = 1'b0;
      evt_wr_c = 1'b0;
      done_c   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {bus.in_ctrl, bus.in_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= 3'd0;
      rd_ptr    <= 3'd0;
      fcount    <= 4'd0;
      h0_data   <= '0;
      h0_ctrl   <= '0;
      h1_data   <= '0;
      h1_ctrl   <= '0;
      flush_sel <= 1'b0;
      flush_end <= 1'b0;
      flush_evt <= 1'b0;
      cnt       <= 8'd0;
      pkt_cnt   <= 32'd0;
      err_cnt   <= 16'd0;
    end else begin
      state <= state_n;
      if (wr_en) wr_ptr <= wr_ptr + 3'd1;
      if (pop)   rd_ptr <= rd_ptr + 3'd1;
      fcount <= fcount + {3'b000, wr_en} - {3'b000, pop};
      if (ld_h0) begin
        h0_data <= head_data;
        h0_ctrl <= head_ctrl;
      end
      if (ld_h1) begin
        h1_data <= head_data;
        h1_ctrl <= head_ctrl;
      end
      if (flush_go) begin
        flush_sel <= 1'b0;
        flush_end <= flush_end_n;
        flush_evt <= flush_evt_n;
      end else if (state == FLUSH && bus.out_rdy) begin
        flush_sel <= ~flush_sel;
      end
      if (cnt_ld)       cnt <= cnt_ld_val;
      else if (cnt_inc) cnt <= cnt + 8'd1;
      if (inc_good && pkt_cnt != '1) pkt_cnt <= pkt_cnt + 32'd1;
      if (inc_err && err_cnt != '1)  err_cnt <= err_cnt + 16'd1;
    end
  end

  assign bus.in_rdy        = ~full;
  assign bus.out_data      = out_data_c;
  assign bus.out_ctrl      = out_ctrl_c;
  assign bus.out_wr        = out_wr_c;
  assign bus.evt_word      = head_data;
  assign bus.evt_wr        = evt_wr_c;
  assign bus.evt_pkt_done  = done_c;
  assign bus.evt_pkt_count = pkt_cnt;
  assign bus.evt_err_count = err_cnt;
  assign dbg_state         = state;
endmodule

// File: tb/tb_evt_pkt_extractor.sv
// Bench for evt_pkt_extractor: packet-level reference model, per-cycle output compare, random traffic.
// Build with EVT_EXTRACT_FWD_EN defined to check the forwarding variant.
module tb_evt_pkt_extractor;
  localparam int          DW  = 64;
  localparam int          CW  = 8;
  localparam int          H   = 7;
  localparam int          P   = 8;
  localparam logic [15:0] ETH = 16'h88B5;
`ifdef EVT_EXTRACT_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] dbg_state;

  evt_pkt_extractor_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus();

  evt_pkt_extractor #(
    .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_WORDS_IN_HDR(H),
    .NUM_WORDS_PAYLOAD(P), .EVT_ETHERTYPE(ETH)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int sink_mode = 0;
  int exp_good = 0;
  int exp_err = 0;
  logic [71:0] exp_out_q[$];
  logic [64:0] exp_evt_q[$];
  logic [63:0] pd[$];
  logic [7:0]  pc[$];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Packet generator: first and last words framed with ctrl!=0, word 2 carries the ethertype.
  task automatic build(input int len, input bit evt);
    pd.delete();
    pc.delete();
    for (int i = 0; i < len; i++) begin
      logic [63:0] d;
      logic [7:0]  c;
      d = {$urandom, $urandom};
      c = (i == 0 || i == len - 1) ? 8'($urandom_range(1, 255)) : 8'h00;
      if (i == 2) begin
        if (evt) d[31:16] = ETH;
        else begin
          d[31:16] = 16'($urandom);
          if (d[31:16] == ETH) d[31:16] = 16'h0800;
        end
      end
      pd.push_back(d);
      pc.push_back(c);
    end
  endtask

  // Reference model: decides per packet what must appear on out_* and evt_*.
  task automatic model_pkt();
    int L;
    int last;
    bit is_evt;
    logic [63:0] w2;
    L = pd.size();
    w2 = (L >= 4) ? pd[2] : 64'd0;
    is_evt = (L >= 4) && (w2[31:16] == ETH);
    if (!is_evt || FWD)
      for (int i = 0; i < L; i++) exp_out_q.push_back({pc[i], pd[i]});
    if (is_evt) begin
      if (L == H + P) begin
        for (int k = 0; k < P; k++) exp_evt_q.push_back({1'(k == P - 1), pd[H + k]});
        exp_good++;
      end else begin
        exp_err++;
        last = (L < H + P) ? L - 2 : H + P - 2;
        for (int i = H; i <= last; i++) exp_evt_q.push_back({1'b0, pd[i]});
      end
    end
  endtask

  task automatic push_word(input logic [63:0] d, input logic [7:0] c);
    bit acc;
    int n;
    n = 0;
    bus.in_data = d;
    bus.in_ctrl = c;
    bus.in_wr   = 1'b1;
    do begin
      @(negedge clk);
      acc = bus.in_rdy;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 2000);
    if (!acc) begin
      vecs++;
      errs++;
      $display("FAIL in_rdy_timeout: got 0 expected 1");
    end
    bus.in_wr = 1'b0;
  endtask

  task automatic feed(input int upto, input bit gaps);
    for (int i = 0; i < upto; i++) begin
      push_word(pd[i], pc[i]);
      if (gaps && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while ((exp_out_q.size() != 0 || exp_evt_q.size() != 0) && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_out_q.size() != 0 || exp_evt_q.size() != 0) begin
      vecs++;
      errs++;
      $display("FAIL %s_drain: got %0d/%0d words left expected 0/0", name, exp_out_q.size(), exp_evt_q.size());
      exp_out_q.delete();
      exp_evt_q.delete();
    end
  endtask

  task automatic drain(input string name);
    wait_empty(name);
    sink_mode = 0;
    repeat (20) begin @(posedge clk); #1; end
    chk({name, "_good_cnt"}, 72'(bus.evt_pkt_count), 72'(exp_good));
    chk({name, "_err_cnt"}, 72'(bus.evt_err_count), 72'(exp_err));
  endtask

  // Sink-side stimulus: out_rdy / evt_full patterns.
  initial begin
    bus.out_rdy  = 1'b1;
    bus.evt_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (sink_mode)
        0: begin bus.out_rdy = 1'b1; bus.evt_full = 1'b0; end
        1: begin bus.out_rdy = 1'b1; bus.evt_full = ~bus.evt_full; end
        2: begin
          bus.out_rdy  = ($urandom_range(0, 3) != 0);
          bus.evt_full = ($urandom_range(0, 3) == 0);
        end
        default: begin
          bus.out_rdy  = ($urandom_range(0, 7) == 0);
          bus.evt_full = ($urandom_range(0, 1) == 0);
        end
      endcase
    end
  end

  // Compare process: every strobe must match the head of the model's queues.
  initial begin
    logic [71:0] eo;
    logic [64:0] ee;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_out_wr", 72'(bus.out_wr), 72'd0);
        chk("rst_evt_wr", 72'(bus.evt_wr), 72'd0);
        chk("rst_done", 72'(bus.evt_pkt_done), 72'd0);
      end else begin
        if (bus.out_wr) begin
          if (exp_out_q.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL out_extra: got %0h expected no word", {bus.out_ctrl, bus.out_data});
          end else begin
            eo = exp_out_q.pop_front();
            chk("out_word", {bus.out_ctrl, bus.out_data}, eo);
          end
        end
        if (bus.evt_wr) begin
          if (exp_evt_q.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL evt_extra: got %0h expected no word", bus.evt_word);
          end else begin
            ee = exp_evt_q.pop_front();
            chk("evt_word_done", 72'({bus.evt_pkt_done, bus.evt_word}), 72'(ee));
          end
        end else begin
          chk("done_without_wr", 72'(bus.evt_pkt_done), 72'd0);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] t;
    bus.in_wr   = 1'b0;
    bus.in_data = '0;
    bus.in_ctrl = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_rdy", 72'(bus.in_rdy), 72'd1);
    chk("post_rst_good", 72'(bus.evt_pkt_count), 72'd0);
    chk("post_rst_err", 72'(bus.evt_err_count), 72'd0);
    @(posedge clk);
    #1;

    // Plain 10-word packet, ethertype 0x0800.
    sink_mode = 0;
    build(10, 1'b0);
    t = pd[2];
    t[31:16] = 16'h0800;
    pd[2] = t;
    model_pkt();
    chk("pin_nonevt_out", 72'(exp_out_q.size()), 72'd10);
    chk("pin_nonevt_evt", 72'(exp_evt_q.size()), 72'd0);
    feed(10, 1'b0);
    drain("nonevt");

    // Good event packet, sink always free.
    build(H + P, 1'b1);
    pc[H + P - 1] = 8'h01;
    model_pkt();
    chk("pin_evt_evt", 72'(exp_evt_q.size()), 72'd8);
    chk("pin_evt_out", 72'(exp_out_q.size()), FWD ? 72'd15 : 72'd0);
    feed(H + P, 1'b0);
    drain("evt_good");
    chk("pin_evt_good", 72'(exp_good), 72'd1);

    // Same with evt_full toggling.
    sink_mode = 1;
    build(H + P, 1'b1);
    pc[H + P - 1] = 8'h01;
    model_pkt();
    feed(H + P, 1'b0);
    drain("evt_toggle");

    // Early end on payload word 5, then a 4-word normal packet.
    build(H + 6, 1'b1);
    pc[H + 5] = 8'h01;
    model_pkt();
    chk("pin_short_evt", 72'(exp_evt_q.size()), 72'd5);
    chk("pin_short_err", 72'(exp_err), 72'd1);
    feed(H + 6, 1'b0);
    build(4, 1'b0);
    model_pkt();
    feed(4, 1'b0);
    drain("evt_short");

    // Reset after the 3rd payload word, then a good event packet.
    build(H + P, 1'b1);
    pc[H + P - 1] = 8'h01;
    for (int i = 0; i < 3; i++) exp_evt_q.push_back({1'b0, pd[H + i]});
    if (FWD) for (int i = 0; i < H + 3; i++) exp_out_q.push_back({pc[i], pd[i]});
    feed(H + 3, 1'b0);
    wait_empty("pre_reset");
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    exp_good = 0;
    exp_err = 0;
    @(negedge clk);
    chk("mid_rst_in_rdy", 72'(bus.in_rdy), 72'd1);
    chk("mid_rst_good", 72'(bus.evt_pkt_count), 72'd0);
    chk("mid_rst_err", 72'(bus.evt_err_count), 72'd0);
    @(posedge clk);
    #1;
    build(H + P, 1'b1);
    pc[H + P - 1] = 8'h01;
    model_pkt();
    chk("pin_after_rst_evt", 72'(exp_evt_q.size()), 72'd8);
    feed(H + P, 1'b0);
    drain("after_rst");

    // Random traffic: lengths, packet kinds, sink stalls and upstream gaps.
    for (int n = 0; n < 40; n++) begin
      int  len;
      bit  evt;
      evt = ($urandom_range(0, 1) == 1);
      len = $urandom_range(2, 20);
      if (evt && $urandom_range(0, 1) == 1) len = H + P;
      sink_mode = $urandom_range(0, 3);
      build(len, evt);
      model_pkt();
      feed(len, 1'b1);
    end
    drain("random");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/evt_pkt_extractor.md
EVT_PKT_EXTRACTOR -- requirements
Module: evt_pkt_extractor

Interface
REQ-001 Param DATA_WIDTH, 64, datapath data width.
REQ-002 Param CTRL_WIDTH, 8, datapath ctrl width.
REQ-003 Param NUM_WORDS_IN_HDR, 7, event header words, module header included.
REQ-004 Param NUM_WORDS_PAYLOAD, 8, event payload words.
REQ-005 Param EVT_ETHERTYPE, 16'h88B5, ethertype identifying event packets.
REQ-006 clk  in  1  clock; reset  in  1  synchronous, active-high.
REQ-007 in_data/in_ctrl/in_wr  in  64/8/1  upstream datapath; in_rdy  out  1  = input FIFO not full.
REQ-008 out_data/out_ctrl/out_wr  out  64/8/1  downstream datapath; out_rdy  in  1.
REQ-009 evt_word  out  64  extracted payload word; evt_wr  out  1  write strobe; evt_full  in  1  sink full.
REQ-010 evt_pkt_done  out  1  one-cycle pulse on last payload word of a good event packet.
REQ-011 evt_pkt_count/evt_err_count  out  32/16  good event packets / malformed event packets.

Function
REQ-012 Input SHALL pass through an 8-deep fall-through FIFO; all read-side decisions use the FIFO head.
REQ-013 Packet = words from first ctrl!=0 word (module header) to next ctrl!=0 word after a ctrl==0 word.
REQ-014 States: IDLE, HOLD1, HOLD2, FLUSH, PASS, EVT_HDR, EVT_PLD, DROP.
REQ-015 IDLE: module header at head -> store in hold reg 0, pop, HOLD1; ctrl==0 at head -> pass as PASS.
REQ-016 HOLD1: store word1 in hold reg 1, pop, HOLD2; no output.
REQ-017 HOLD2: ethertype = head data[31:16]; match -> pop, discard holds, EVT_HDR; else FLUSH without popping.
REQ-018 HOLD1 with ctrl!=0 at head (short packet) -> store, FLUSH, packet then ends after replay.
REQ-019 FLUSH: replay hold 0 then hold 1, one per cycle with out_rdy=1; then PASS (or IDLE if packet ended).
REQ-020 PASS: head forwarded, out_wr=in_fifo_rd_en=1 when !empty & out_rdy; end-of-packet -> IDLE.
REQ-021 EVT_HDR: pop remaining header words (word index 3..NUM_WORDS_IN_HDR-1), no output, then EVT_PLD.
REQ-022 EVT_PLD: per pop evt_word=head data, evt_wr=1, only when !empty & !evt_full.
REQ-023 Payload word k<NUM_WORDS_PAYLOAD-1 must have ctrl==0; last must have ctrl!=0; then evt_pkt_done=1, evt_pkt_count++, IDLE.
REQ-024 Violation (ctrl!=0 early or ctrl==0 on last, or ctrl!=0 in EVT_HDR) -> evt_err_count++, no evt_pkt_done, DROP.
REQ-025 DROP: pop until end-of-packet (inclusive, or immediately if violating word ended it), then IDLE; no outputs.
REQ-026 Word ordering and contents on out_* SHALL equal input exactly for non-event packets.
REQ-027 Counters SHALL saturate at all-ones.
REQ-028 Latency: FIFO head to out_*/evt_* zero cycles (combinational from head); end-to-end one cycle minimum, plus 2 cycles FLUSH stall per non-event packet.
REQ-029 Stalls: out_rdy=0 freezes PASS/FLUSH; evt_full=0 required for EVT_PLD; EVT_HDR/DROP never stall on sinks.
REQ-030 FIFO full: in_rdy=0; in_wr while full SHALL be ignored, upstream violation only.

Reset
REQ-031 Reset SHALL empty FIFO, clear holds, state=IDLE, both counters=0.
REQ-032 During/after reset out_wr=evt_wr=evt_pkt_done=0, in_rdy=1 next cycle.
REQ-033 Reset mid-packet SHALL abandon it with no evt_pkt_done and no counter change beyond clear.

Configuration
REQ-034 Macro EVT_EXTRACT_FWD_EN: defined -> event packets are also forwarded unchanged on out_* (FLUSH replay then PASS-like copy), EVT_HDR/EVT_PLD/DROP pop only when out_rdy & (!evt_full where writing).
REQ-035 Without EVT_EXTRACT_FWD_EN event packets are consumed, never appear on out_*.

Verification
REQ-036 Non-event 10-word packet, ethertype 0x0800 -> identical 10 words on out_*, evt_wr never asserted, counts 0.
REQ-037 Event packet 7 hdr + 8 payload (last ctrl=0x01), evt_full=0 -> 8 evt_wr with payload data, done on 8th, evt_pkt_count=1, no out_wr.
REQ-038 Same event packet with evt_full toggling every other cycle -> same 8 words in order, none duplicated or lost.
REQ-039 Event packet with ctrl=0x01 on payload word 5 -> evt_err_count=1, no done, following 4-word normal packet forwarded intact.
REQ-040 Reset asserted after 3rd payload word, then good event packet -> evt_pkt_count=1, evt_err_count=0, exactly 8 evt_wr after reset.
REQ-041 With EVT_EXTRACT_FWD_EN, event packet -> 15 words on out_* and 8 evt_wr, evt_pkt_count=1.
